// File: rtl/mips_trace_buffer.sv
// Instruction trace buffer for a MIPS core: captures {jump, pc, instr} into a
// circular store once armed, with wrap/drop full policy and halt-on-match.
module mips_trace_buffer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TEST_W    = 16,
  parameter int DEPTH     = 16,
  parameter int WRAP      = 1,
  parameter int JUMP_ONLY = 0
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic                         arm,
  input  logic                         clr,
  input  logic                         valid_in,
  input  logic [ADDR_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            instr_in,
  input  logic                         jump_in,
  input  logic [TEST_W-1:0]            test_value_in,
  input  logic                         halt_en,
  input  logic [TEST_W-1:0]            halt_value,
  input  logic                         rd_en,
  output logic [ADDR_W+DATA_W:0]       rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic [1:0]                   state
);

  localparam int EW = 1 + ADDR_W + DATA_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_HALTED  = 2'd2;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          wr_req, match, pop, do_write, lost;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full-buffer write is only lost when no pop frees a slot in the same cycle.
  always_comb begin
    wr_req   = !clr && (state == S_CAPTURE) && valid_in && ((JUMP_ONLY == 0) || jump_in);
    match    = !clr && (state == S_CAPTURE) && halt_en && valid_in &&
               (test_value_in == halt_value);
    pop      = !clr && rd_en && !empty;
    lost     = wr_req && full && !pop;
    do_write = wr_req && (!lost || (WRAP != 0));
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wptr] <= {jump_in, pc_in, instr_in};
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clr) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[rptr];
      if (do_write) wptr <= wptr + PW'(1);
      // Overwriting the oldest entry drags the read pointer along with it.
      if (pop || (lost && (WRAP != 0))) rptr <= rptr + PW'(1);
      if (do_write && !pop && !full) count <= count + CW'(1);
      else if (pop && !do_write)     count <= count - CW'(1);
      if (lost) overflow <= 1'b1;
      case (state)
        S_IDLE:    if (arm) state <= S_CAPTURE;
        S_CAPTURE: if (match || (lost && (WRAP == 0))) state <= S_HALTED;
        S_HALTED:  state <= S_HALTED;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: three instances (wrap, drop, jump-only) share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_mips_trace_buffer;
  localparam int AW = 32, DW = 32, TW = 16, DEPTH = 4, N = 3;
  localparam int EW = 1 + AW + DW;
  localparam int CW = $clog2(DEPTH + 1);
  localparam bit [N-1:0] WRAPS = 3'b101;
  localparam bit [N-1:0] JOS   = 3'b100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset, arm, clr, valid_in, jump_in, halt_en, rd_en;
  logic [AW-1:0] pc_in;
  logic [DW-1:0] instr_in;
  logic [TW-1:0] test_value_in, halt_value;

  logic [EW-1:0] rd_data [N];
  logic          rd_valid[N], full[N], empty[N], overflow[N];
  logic [CW-1:0] count   [N];
  logic [1:0]    state   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    mips_trace_buffer #(
      .ADDR_W(AW), .DATA_W(DW), .TEST_W(TW), .DEPTH(DEPTH),
      .WRAP(int'(WRAPS[g])), .JUMP_ONLY(int'(JOS[g]))
    ) u_dut (
      .clk(clk), .areset(areset), .arm(arm), .clr(clr), .valid_in(valid_in),
      .pc_in(pc_in), .instr_in(instr_in), .jump_in(jump_in),
      .test_value_in(test_value_in), .halt_en(halt_en), .halt_value(halt_value),
      .rd_en(rd_en), .rd_data(rd_data[g]), .rd_valid(rd_valid[g]),
      .count(count[g]), .full(full[g]), .empty(empty[g]),
      .overflow(overflow[g]), .state(state[g])
    );
  end

  // Reference model: a bounded queue per instance plus state as 0/1/2.
  logic [EW-1:0] mq [N][$];
  int            mst [N];
  bit            movf[N], mrv[N];
  logic [EW-1:0] mrd [N];

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      mst[i] = 0; movf[i] = 0; mrv[i] = 0; mrd[i] = '0;
    end
  endtask

  task automatic model_step();
    logic [EW-1:0] e;
    e = {jump_in, pc_in, instr_in};
    for (int i = 0; i < N; i++) begin
      bit pop, wr, match, isfull;
      if (clr) begin
        mq[i].delete(); movf[i] = 0; mrv[i] = 0; mst[i] = 0;
        continue;
      end
      isfull = (mq[i].size() == DEPTH);
      pop    = rd_en && (mq[i].size() != 0);
      wr     = (mst[i] == 1) && valid_in && (!JOS[i] || jump_in);
      match  = (mst[i] == 1) && halt_en && valid_in && (test_value_in == halt_value);
      mrv[i] = pop;
      if (pop) mrd[i] = mq[i].pop_front();
      if (wr) begin
        if (isfull && !pop) begin
          movf[i] = 1;
          if (WRAPS[i]) begin
            void'(mq[i].pop_front());
            mq[i].push_back(e);
          end else mst[i] = 2;
        end else mq[i].push_back(e);
      end
      if (mst[i] == 0 && arm) mst[i] = 1;
      else if (match)         mst[i] = 2;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      check($sformatf("rd_valid%0d", i), rd_valid[i], mrv[i]);
      check($sformatf("rd_data%0d", i),  rd_data[i],  mrd[i]);
      check($sformatf("count%0d", i),    count[i],    mq[i].size());
      check($sformatf("full%0d", i),     full[i],     mq[i].size() == DEPTH);
      check($sformatf("empty%0d", i),    empty[i],    mq[i].size() == 0);
      check($sformatf("overflow%0d", i), overflow[i], movf[i]);
      check($sformatf("state%0d", i),    state[i],    mst[i]);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic cyc(input bit a, input bit c, input bit v, input bit j, input bit r,
                     input logic [AW-1:0] pc, input logic [TW-1:0] tv);
    arm = a; clr = c; valid_in = v; jump_in = j; rd_en = r;
    pc_in = pc; instr_in = $urandom; test_value_in = tv;
    step();
    arm = 0; clr = 0; valid_in = 0; jump_in = 0; rd_en = 0; test_value_in = '0;
  endtask

  task automatic async_reset();
    areset = 0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    areset = 1;
  endtask

  initial begin
    areset = 0; arm = 0; clr = 0; valid_in = 0; jump_in = 0; rd_en = 0;
    halt_en = 0; halt_value = '0; pc_in = '0; instr_in = '0; test_value_in = '0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    areset = 1;

    // Basic capture and in-order pops
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 0, AW'(4 * k), 0);
    check("basic_count", count[0], 3);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("basic_rv", rd_valid[0], 1);
      check("basic_pc", rd_data[0][DW +: AW], 4 * k);
    end
    check("basic_empty", empty[0], 1);

    // Wrap overwrite vs drop-and-halt
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, 0, AW'(4 * k), 0);
    check("wrap_count", count[0], 4);
    check("wrap_ovf", overflow[0], 1);
    check("drop_state", state[1], 2);
    check("drop_count", count[1], 4);
    check("drop_ovf", overflow[1], 1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0);
      check("wrap_pc", rd_data[0][DW +: AW], 8 + 4 * k);
      check("drop_pc", rd_data[1][DW +: AW], 4 * k);
    end
    cyc(0, 0, 1, 0, 0, 32'h40, 0);
    check("halted_nowrite", count[1], 0);

    // Halt on match
    cyc(0, 1, 0, 0, 0, 0, 0);
    halt_en = 1; halt_value = 16'h0007;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 32'h100, 3);
    cyc(0, 0, 1, 1, 0, 32'h104, 7);
    check("match_count", count[0], 2);
    check("match_state", state[0], 2);
    cyc(0, 0, 1, 1, 0, 32'h108, 0);
    check("match_nowrite", count[0], 2);
    halt_en = 0;

    // Simultaneous events
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, 0, AW'(4 * k), 0);
    cyc(0, 0, 1, 0, 1, 32'h200, 0);
    check("fullrw_count", count[0], 4);
    check("fullrw_ovf", overflow[0], 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h300, 0);
    check("emptyrw_count", count[0], 1);
    check("emptyrw_rv", rd_valid[0], 0);
    cyc(1, 1, 1, 1, 1, 32'h304, 0);
    check("clrarm_state", state[0], 0);
    check("clrarm_count", count[0], 0);

    // Jump filter, then asynchronous reset mid-capture
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, (k == 1 || k == 3), 0, AW'(4 * k), 0);
    check("filter_count", count[2], 2);
    async_reset();
    check("areset_state", state[0], 0);
    check("areset_empty", empty[2], 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
        continue;
      end
      halt_en    = ($urandom_range(0, 3) == 0);
      halt_value = TW'($urandom_range(0, 15));
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
          $urandom, TW'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
